countdown_timer_core: RTL and testbench

Countdown counterpart of the stopwatch datapath. It loads a MM:SS.cc start value, decrements it in cascaded BCD digits once every 10 ms tick, and signals expiry. It sits between the debounced start/stop button and the 7-segment scan/decode logic, and exposes six BCD digits in the same format the stopwatch feeds to the display.

---
 rtl/timer_pkg.sv | 44 ++++
 rtl/countdown_timer_core_if.sv | 22 ++
 rtl/bcd_down_digit.sv | 28 ++
 rtl/countdown_timer_core.sv | 91 +++++++++
 tb/tb_countdown_timer_core.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS.cc countdown timer.
// Digit index 0 is centiseconds ones, index 5 is minutes tens.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam int unsigned BCD_W      = 4;
  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned VALUE_W    = BCD_W * NUM_DIGITS;

  localparam logic [BCD_W-1:0] DIGIT_MAX_9 = 4'd9;
  localparam logic [BCD_W-1:0] DIGIT_MAX_5 = 4'd5;

  localparam int unsigned CS_ONES_LSB  = 0;
  localparam int unsigned CS_TENS_LSB  = 4;
  localparam int unsigned SEC_ONES_LSB = 8;
  localparam int unsigned SEC_TENS_LSB = 12;
  localparam int unsigned MIN_ONES_LSB = 16;
  localparam int unsigned MIN_TENS_LSB = 20;

  localparam int unsigned SEC_TENS_IDX = 3;
  localparam int unsigned MIN_TENS_IDX = 5;

  function automatic logic [BCD_W-1:0] digit_max(input int unsigned idx);
    return (idx == SEC_TENS_IDX || idx == MIN_TENS_IDX) ? DIGIT_MAX_5 : DIGIT_MAX_9;
  endfunction

  function automatic int unsigned digit_lsb(input int unsigned idx);
    case (idx)
      0:       return CS_ONES_LSB;
      1:       return CS_TENS_LSB;
      2:       return SEC_ONES_LSB;
      3:       return SEC_TENS_LSB;
      4:       return MIN_ONES_LSB;
      default: return MIN_TENS_LSB;
    endcase
  endfunction

endpackage

// File: rtl/countdown_timer_core_if.sv
// Control/display bundle between the button/display logic and the countdown core.
interface countdown_timer_core_if;
  import timer_pkg::*;

  logic               load;
  logic [VALUE_W-1:0] load_value;
  logic               start_stop;
  logic [VALUE_W-1:0] digits;
  logic               running;
  logic               zero;
  logic               done;

  modport master (
    output load, load_value, start_stop,
    input  digits, running, zero, done
  );

  modport slave (
    input  load, load_value, start_stop,
    output digits, running, zero, done
  );
endinterface

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with load clamping and borrow to the next digit.
module bcd_down_digit
  import timer_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX = DIGIT_MAX_9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic             dec_in,
  output logic [BCD_W-1:0] q,
  output logic             borrow_out
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= (load_val > MAX) ? MAX : load_val;
    end else if (dec_in) begin
      q <= (q == '0) ? MAX : q - BCD_W'(1);
    end
  end

  assign borrow_out = dec_in & (q == '0);

endmodule

// File: rtl/countdown_timer_core.sv
// MM:SS.cc countdown: run/pause FSM, 10 ms prescaler, six-digit BCD borrow chain
// and a one-cycle expiry pulse.
module countdown_timer_core
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  countdown_timer_core_if.slave bus
);

  localparam int unsigned PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] TICK_LAST = PRESC_W'(TICK_DIV - 1);

  state_t               state_q, state_d;
  logic [PRESC_W-1:0]   presc_q;
  logic                 running_q;
  logic                 done_q;
  logic [VALUE_W-1:0]   value;
  logic [NUM_DIGITS:0]  borrow;
  logic                 tick_c;
  logic                 zero_c;
  logic                 expire_c;
  logic                 digit_load_c;

  assign tick_c = (state_q == RUN) && (presc_q == TICK_LAST);
  assign zero_c = (value == '0);
  // Expiry when this tick takes 00:00.01 to zero; a chain underflow is treated the same way.
  assign expire_c = tick_c && !bus.load && ((value == VALUE_W'(1)) || borrow[NUM_DIGITS]);
  assign digit_load_c = bus.load || expire_c;
  assign borrow[0] = tick_c;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    localparam int unsigned LSB = digit_lsb(i);
    bcd_down_digit #(
      .MAX(digit_max(i))
    ) u_digit (
      .clk       (clk),
      .reset     (reset),
      .load      (digit_load_c),
      .load_val  (bus.load ? bus.load_value[LSB +: BCD_W] : '0),
      .dec_in    (borrow[i]),
      .q         (value[LSB +: BCD_W]),
      .borrow_out(borrow[i+1])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == RUN);
      done_q    <= expire_c;
      if (bus.load || expire_c || tick_c) begin
        presc_q <= '0;
      end else if (state_q == RUN) begin
        presc_q <= presc_q + PRESC_W'(1);
      end
    end
  end

  // Load wins over everything; expiry wins over a coincident pause request.
  always_comb begin
    state_d = state_q;
    if (bus.load) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.start_stop && !zero_c) state_d = RUN;
        RUN: begin
          if (expire_c)            state_d = EXPIRED;
          else if (bus.start_stop) state_d = PAUSE;
        end
        PAUSE:   if (bus.start_stop) state_d = RUN;
        EXPIRED: if (bus.start_stop) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.digits  = value;
  assign bus.running = running_q;
  assign bus.zero    = zero_c;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_countdown_timer_core.sv
// Scoreboard bench for countdown_timer_core: the driver pushes expected outputs from a
// centisecond-arithmetic reference model; a negedge monitor pops and compares.
module tb_countdown_timer_core;

  localparam int TD = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

  typedef struct {
    logic [23:0] digits;
    bit          running;
    bit          zero;
    bit          done;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  countdown_timer_core_if bus ();

  countdown_timer_core #(.TICK_DIV(TD)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;

  int m_val   = 0;
  int m_mode  = M_IDLE;
  int m_phase = 0;
  bit m_done  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int clamp_cs(input logic [23:0] lv);
    int mt, mo, st, so, ct, co;
    mt = int'(lv[23:20]); mo = int'(lv[19:16]);
    st = int'(lv[15:12]); so = int'(lv[11:8]);
    ct = int'(lv[7:4]);   co = int'(lv[3:0]);
    if (mt > 5) mt = 5;
    if (mo > 9) mo = 9;
    if (st > 5) st = 5;
    if (so > 9) so = 9;
    if (ct > 9) ct = 9;
    if (co > 9) co = 9;
    return (mt * 10 + mo) * 6000 + (st * 10 + so) * 100 + ct * 10 + co;
  endfunction

  function automatic logic [23:0] to_bcd(input int v);
    int cs, s, m;
    cs = v % 100;
    s  = (v / 100) % 60;
    m  = v / 6000;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
  endfunction

  // Apply inputs for one cycle, advance the model, queue the expected post-edge outputs.
  task automatic step(input bit ld, input logic [23:0] lv, input bit ss);
    exp_t e;
    bit   tick;
    bus.load       = ld;
    bus.load_value = lv;
    bus.start_stop = ss;
    m_done = 1'b0;
    if (!reset) begin
      m_val = 0; m_mode = M_IDLE; m_phase = 0;
    end else if (ld) begin
      m_val = clamp_cs(lv); m_mode = M_IDLE; m_phase = 0;
    end else begin
      case (m_mode)
        M_IDLE:  if (ss && m_val != 0) m_mode = M_RUN;
        M_RUN: begin
          tick = (m_phase == TD - 1);
          m_phase = tick ? 0 : m_phase + 1;
          if (tick) m_val = m_val - 1;
          if (tick && m_val == 0) begin
            m_mode = M_EXP; m_done = 1'b1; m_phase = 0;
          end else if (ss) begin
            m_mode = M_PAUSE;
          end
        end
        M_PAUSE: if (ss) m_mode = M_RUN;
        default: if (ss) m_mode = M_IDLE;
      endcase
    end
    e.digits  = to_bcd(m_val);
    e.running = (m_mode == M_RUN);
    e.zero    = (m_val == 0);
    e.done    = m_done;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.load       = 1'b0;
    bus.start_stop = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 24'h0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("digits",  32'(bus.digits),  32'(mon_e.digits));
      chk("running", 32'(bus.running), 32'(mon_e.running));
      chk("zero",    32'(bus.zero),    32'(mon_e.zero));
      chk("done",    32'(bus.done),    32'(mon_e.done));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] lv;
    bus.load = 1'b0;
    bus.load_value = '0;
    bus.start_stop = 1'b0;

    // Reset state, then release
    idle(2);
    reset = 1'b1;
    idle(1);

    // 00:00.03 counts down to expiry, then acknowledge
    step(1'b1, 24'h000003, 1'b0);
    step(1'b0, 24'h0, 1'b1);
    idle(14);
    step(1'b0, 24'h0, 1'b1);
    idle(2);

    // Full borrow ripple 01:00.00 -> 00:59.99
    step(1'b1, 24'h010000, 1'b0);
    step(1'b0, 24'h0, 1'b1);
    idle(6);

    // Pause/resume keeps the prescaler phase
    step(1'b1, 24'h000010, 1'b0);
    step(1'b0, 24'h0, 1'b1);
    idle(5);
    step(1'b0, 24'h0, 1'b1);
    idle(20);
    step(1'b0, 24'h0, 1'b1);
    idle(6);

    // Clamped load, and load beating a coincident start_stop
    step(1'b1, 24'hFFFFFF, 1'b0);
    step(1'b1, 24'h123456, 1'b1);
    idle(3);

    // Start/stop coincident with the expiring tick
    step(1'b1, 24'h000001, 1'b0);
    step(1'b0, 24'h0, 1'b1);
    idle(3);
    step(1'b0, 24'h0, 1'b1);
    idle(2);

    // Asynchronous reset in mid-count
    step(1'b1, 24'h000500, 1'b0);
    step(1'b0, 24'h0, 1'b1);
    idle(7);
    @(negedge clk);
    #2;
    chk("sb_drain_pre_reset", 32'(sb.size()), 32'd0);
    reset = 1'b0;
    #1;
    chk("async_rst_digits",  32'(bus.digits),  32'd0);
    chk("async_rst_running", 32'(bus.running), 32'd0);
    chk("async_rst_zero",    32'(bus.zero),    32'd1);
    m_val = 0; m_mode = M_IDLE; m_phase = 0;
    idle(2);
    reset = 1'b1;
    step(1'b0, 24'h0, 1'b1);
    idle(3);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit ld, ss;
      ld = ($urandom_range(0, 59) == 0);
      ss = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) lv = 24'($urandom);
      else lv = {16'h0000, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
      step(ld, lv, ss);
    end

    @(negedge clk);
    #1;
    chk("sb_drain_final", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
